// File: rtl/cache_mem_arbiter_if.sv
// Memory-side bus between the cache wrapper and the single RAM port.
// master is the arbiter's view; slave is the view of the caches and RAM around it.
interface cache_mem_arbiter_if;
   // Handshake: a requester raises iREN or dREN/dWEN and holds its address and data
   // stable while its wait is 1. The transfer completes in the one cycle where the
   // wait is 0, which is exactly the cycle in which RAM reports ACCESS for that grant.
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        mem_err;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, mem_err
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, mem_err
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache. dcache wins contention unless
// icache has watched STARVE_LIMIT consecutive dcache completions.
module cache_mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   cache_mem_arbiter_if.master bus,
   output logic [1:0]       dbg_state,
   output logic [CNT_W-1:0] dbg_starve_cnt
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   localparam logic [1:0]       RAM_ACCESS = 2'b10;
   localparam logic [1:0]       RAM_ERROR  = 2'b11;
   localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_t           state, state_nx;
   logic [CNT_W-1:0] starve_cnt;
   logic             d_req;
   logic             i_done;
   logic             d_done;

   assign d_req  = bus.dREN || bus.dWEN;
   assign i_done = (state == GRANT_I) && (bus.ramstate == RAM_ACCESS) && bus.iREN;
   assign d_done = (state == GRANT_D) && (bus.ramstate == RAM_ACCESS) && d_req;

   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'h0;
      bus.ramstore = 32'h0;
      bus.iload    = 32'h0;
      bus.dload    = 32'h0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      unique case (state)
         IDLE: begin
            if (bus.iREN && (!d_req || (starve_cnt >= LIMIT))) begin
               state_nx = GRANT_I;
            end else if (d_req) begin
               state_nx = GRANT_D;
            end
         end
         GRANT_I: begin
            bus.ramREN  = bus.iREN;
            bus.ramaddr = bus.iaddr;
            bus.iload   = bus.ramload;
            bus.iwait   = !i_done;
            // A dropped iREN abandons the grant without a completion pulse.
            if ((bus.ramstate == RAM_ACCESS) || !bus.iREN) begin
               state_nx = IDLE;
            end
         end
         GRANT_D: begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.dload    = bus.ramload;
            // A write takes priority if dcache raises both enables.
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN && !bus.dWEN;
            bus.dwait    = !d_done;
            if ((bus.ramstate == RAM_ACCESS) || !d_req) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         starve_cnt <= '0;
      end else if (!bus.iREN || i_done) begin
         starve_cnt <= '0;
      end else if (d_done && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // ERROR is otherwise treated like BUSY; only this sticky flag records it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bus.mem_err <= 1'b0;
      end else if ((state != IDLE) && (bus.ramstate == RAM_ERROR)) begin
         bus.mem_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs change 1ns after a rising edge,
// outputs are checked 1ns later, well before the next edge.
module tb_cache_mem_arbiter;
  logic       CLK;
  logic       nRST;
  logic [1:0] dbg_state;
  logic [3:0] dbg_starve_cnt;
  int         checks = 0;
  int         errors = 0;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .bus            (bus.master),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST         = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h40;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.ramload  = 32'h0;
    bus.ramstate = 2'b00;
    #3;
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst_cnt", 32'(dbg_starve_cnt), 0);
    chk("rst_ramREN", 32'(bus.ramREN), 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_iwait", 32'(bus.iwait), 1);
    chk("rst_dwait", 32'(bus.dwait), 1);
    chk("rst_mem_err", 32'(bus.mem_err), 0);
    #4 nRST = 1'b1;

    // 1: lone icache read, two BUSY cycles then ACCESS
    tick();
    bus.ramstate = 2'b01;
    #1;
    chk("t1_state_gi", 32'(dbg_state), 1);
    chk("t1_ramREN", 32'(bus.ramREN), 1);
    chk("t1_ramaddr", bus.ramaddr, 32'h40);
    chk("t1_iwait_busy", 32'(bus.iwait), 1);
    tick();
    #1;
    chk("t1_iwait_busy2", 32'(bus.iwait), 1);
    tick();
    bus.ramstate = 2'b10;
    bus.ramload  = 32'hDEADBEEF;
    #1;
    chk("t1_iwait_access", 32'(bus.iwait), 0);
    chk("t1_iload", bus.iload, 32'hDEADBEEF);
    chk("t1_dwait", 32'(bus.dwait), 1);
    tick();
    bus.iREN     = 1'b0;
    bus.ramstate = 2'b00;
    bus.ramload  = 32'h0;
    #1;
    chk("t1_idle", 32'(dbg_state), 0);
    chk("t1_iwait_idle", 32'(bus.iwait), 1);

    // 2: simultaneous requests, dcache first, then icache
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h44;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h80;
    tick();
    bus.ramstate = 2'b10;
    bus.ramload  = 32'h11112222;
    #1;
    chk("t2_state_gd", 32'(dbg_state), 2);
    chk("t2_ramaddr", bus.ramaddr, 32'h80);
    chk("t2_dwait", 32'(bus.dwait), 0);
    chk("t2_dload", bus.dload, 32'h11112222);
    chk("t2_iwait", 32'(bus.iwait), 1);
    tick();
    bus.dREN     = 1'b0;
    bus.ramstate = 2'b00;
    #1;
    chk("t2_idle_gap", 32'(dbg_state), 0);
    chk("t2_cnt1", 32'(dbg_starve_cnt), 1);
    tick();
    bus.ramstate = 2'b10;
    #1;
    chk("t2_state_gi", 32'(dbg_state), 1);
    chk("t2_iwait", 32'(bus.iwait), 0);
    chk("t2_ramaddr_i", bus.ramaddr, 32'h44);
    tick();
    #1;
    chk("t2_cnt0", 32'(dbg_starve_cnt), 0);

    // 3: starvation, four dcache writes then icache forced in
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'hC0;
    bus.dstore = 32'hA5A5A5A5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t3_state_gd", 32'(dbg_state), 2);
      chk("t3_dwait", 32'(bus.dwait), 0);
      tick();
      chk("t3_cnt", 32'(dbg_starve_cnt), 32'(k));
    end
    tick();
    chk("t3_forced_gi", 32'(dbg_state), 1);
    chk("t3_iwait", 32'(bus.iwait), 0);
    chk("t3_ramWEN", 32'(bus.ramWEN), 0);
    chk("t3_dwait_held", 32'(bus.dwait), 1);
    tick();
    chk("t3_cnt_clr", 32'(dbg_starve_cnt), 0);
    bus.iREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.ramstate = 2'b00;
    tick();

    // 4: read+write conflict, write wins
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h100;
    bus.dstore = 32'h12345678;
    tick();
    bus.ramstate = 2'b01;
    #1;
    chk("t4_ramWEN", 32'(bus.ramWEN), 1);
    chk("t4_ramREN", 32'(bus.ramREN), 0);
    chk("t4_ramaddr", bus.ramaddr, 32'h100);
    chk("t4_ramstore", bus.ramstore, 32'h12345678);
    chk("t4_dwait_busy", 32'(bus.dwait), 1);
    bus.ramstate = 2'b10;
    #1;
    chk("t4_dwait_access", 32'(bus.dwait), 0);
    tick();
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.ramstate = 2'b00;
    #1;
    chk("t4_idle", 32'(dbg_state), 0);

    // 5: ERROR for three cycles, then icache abandons
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h200;
    tick();
    bus.ramstate = 2'b11;
    #1;
    chk("t5_iwait_err", 32'(bus.iwait), 1);
    chk("t5_mem_err_pre", 32'(bus.mem_err), 0);
    tick();
    chk("t5_mem_err_set", 32'(bus.mem_err), 1);
    chk("t5_held_gi", 32'(dbg_state), 1);
    tick();
    chk("t5_iwait_err3", 32'(bus.iwait), 1);
    tick();
    bus.iREN     = 1'b0;
    bus.ramstate = 2'b00;
    #1;
    chk("t5_iwait_abandon", 32'(bus.iwait), 1);
    chk("t5_ramREN_abandon", 32'(bus.ramREN), 0);
    tick();
    chk("t5_idle", 32'(dbg_state), 0);
    chk("t5_mem_err_sticky", 32'(bus.mem_err), 1);

    // 6: reset asserted in the middle of a dcache write grant
    bus.iREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h300;
    bus.dstore = 32'h0BADF00D;
    tick();
    bus.ramstate = 2'b10;
    tick();
    bus.ramstate = 2'b01;
    tick();
    chk("t6_state_gd", 32'(dbg_state), 2);
    chk("t6_cnt1", 32'(dbg_starve_cnt), 1);
    chk("t6_ramWEN_pre", 32'(bus.ramWEN), 1);
    #1 nRST = 1'b0;
    #1;
    chk("t6_ramWEN_rst", 32'(bus.ramWEN), 0);
    chk("t6_dwait_rst", 32'(bus.dwait), 1);
    chk("t6_cnt_rst", 32'(dbg_starve_cnt), 0);
    chk("t6_mem_err_rst", 32'(bus.mem_err), 0);
    bus.iREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.ramstate = 2'b00;
    #1 nRST = 1'b1;
    tick();
    chk("t6_state_idle", 32'(dbg_state), 0);
    chk("t6_cnt_after", 32'(dbg_starve_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
